// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : run_controller
//  Purpose  : Drives the processor control pins (addr, wr, wdata, working,
//             rID). It loads a program image from a valid/ready stream, runs
//             the core until it halts or times out, waits for the pipeline to
//             drain, then streams r0..r(NREG-1) out over a valid/ready port.
//  Options  : RUN_CTRL_CYCLE_COUNT_EN - adds run_cycles[15:0], the number of
//             cycles p_working was high in the most recent RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 150,
    parameter int NREG    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    output logic              ld_ready,
    output logic [31:0]       p_addr,
    output logic              p_wr,
    output logic [31:0]       p_wdata,
    output logic              p_working,
    output logic [3:0]        p_rID,
    input  logic [31:0]       p_rdata,
    input  logic              p_halted,
    output logic              dump_valid,
    output logic [31:0]       dump_data,
    output logic [3:0]        dump_idx,
    input  logic              dump_ready,
    output logic              busy,
    output logic              timed_out
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    ,output logic [15:0]      run_cycles
`endif
);

    // State encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // RUN counter only has to reach TIMEOUT-1
    localparam int                c_RUN_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(TIMEOUT - 1);
    // Largest program that fits the RAM: 2^ADDR_W words
    localparam logic [ADDR_W:0]   c_LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]        c_LAST_REG = 4'(NREG - 1);
    localparam logic [3:0]        c_RID_IDLE = 4'hF;

    logic [2:0]          r_state;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W:0]     r_ld_cnt;
    logic [c_RUN_W-1:0]  r_run_cnt;
    logic                r_working;
    logic                r_drain_cnt;
    logic [3:0]          r_rid;
    logic                r_dump_valid;
    logic [31:0]         r_dump_data;
    logic [3:0]          r_dump_idx;
    logic                r_timed_out;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [15:0]         r_run_cycles;
`endif

    logic                w_in_load;
    logic                w_xfer;
    logic [ADDR_W:0]     w_len_clamped;
    logic [ADDR_W:0]     w_len_m1;

    // A load word transfers whenever the host offers one during LOAD
    assign w_in_load     = (r_state == S_LOAD);
    assign w_xfer        = w_in_load & ld_valid;
    assign w_len_clamped = (prog_len > c_LEN_MAX) ? c_LEN_MAX : prog_len;
    assign w_len_m1      = r_len - 1'b1;

    // RAM write port is driven combinationally so the word lands on the
    // same edge the handshake completes; outside LOAD the address is 0 so
    // the core's PC starts from word 0 when p_working rises.
    assign ld_ready   = w_in_load;
    assign p_wr       = w_xfer;
    assign p_addr     = w_in_load ? {{(32-ADDR_W){1'b0}}, r_ld_cnt[ADDR_W-1:0]} : 32'd0;
    assign p_wdata    = w_xfer ? ld_data : 32'd0;
    assign p_working  = r_working;
    assign p_rID      = r_rid;
    assign dump_valid = r_dump_valid;
    assign dump_data  = r_dump_data;
    assign dump_idx   = r_dump_idx;
    assign busy       = (r_state != S_IDLE);
    assign timed_out  = r_timed_out;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    assign run_cycles = r_run_cycles;
`endif

    // Sequencer: load -> run -> drain -> dump -> done, with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_ld_cnt     <= '0;
            r_run_cnt    <= '0;
            r_working    <= 1'b0;
            r_drain_cnt  <= 1'b0;
            r_rid        <= c_RID_IDLE;
            r_dump_valid <= 1'b0;
            r_dump_data  <= 32'd0;
            r_dump_idx   <= 4'd0;
            r_timed_out  <= 1'b0;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
            r_run_cycles <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len       <= w_len_clamped;
                        r_ld_cnt    <= '0;
                        r_run_cnt   <= '0;
                        r_timed_out <= 1'b0;
                        r_state     <= (prog_len != '0) ? S_LOAD : S_RUN;
                    end
                end

                S_LOAD: begin
                    if (w_xfer) begin
                        r_ld_cnt <= r_ld_cnt + 1'b1;
                        if (r_ld_cnt == w_len_m1) begin
                            r_state <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    // First RUN cycle keeps the core stopped with addr=0
                    if (!r_working) begin
                        r_working <= 1'b1;
                        r_run_cnt <= '0;
                    end else if (p_halted || (r_run_cnt == c_RUN_LAST)) begin
                        // A halt on the final allowed cycle is a clean exit
                        r_working   <= 1'b0;
                        r_drain_cnt <= 1'b0;
                        r_timed_out <= ~p_halted;
                        r_state     <= S_DRAIN;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
                        r_run_cycles <= 16'(r_run_cnt) + 16'd1;
`endif
                    end else begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    // Two idle cycles let in-flight E/W writes retire
                    if (r_drain_cnt) begin
                        r_rid   <= 4'd0;
                        r_state <= S_DUMP;
                    end else begin
                        r_drain_cnt <= 1'b1;
                    end
                end

                S_DUMP: begin
                    // Invalid cycle doubles as the register-file read settle
                    if (!r_dump_valid) begin
                        r_dump_valid <= 1'b1;
                        r_dump_data  <= p_rdata;
                        r_dump_idx   <= r_rid;
                    end else if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_rid == c_LAST_REG) begin
                            r_rid   <= c_RID_IDLE;
                            r_state <= S_DONE;
                        end else begin
                            r_rid <= r_rid + 4'd1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_controller
//  Purpose  : Directed self-checking bench for run_controller. Models the
//             processor as a fixed register file plus an instruction RAM
//             written through p_addr/p_wr/p_wdata.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_controller;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 150;
    localparam int NREG    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  prog_len = 6'd0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic        ld_ready;
    logic [31:0] p_addr;
    logic        p_wr;
    logic [31:0] p_wdata;
    logic        p_working;
    logic [3:0]  p_rID;
    logic [31:0] p_rdata;
    logic        p_halted = 1'b0;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic [3:0]  dump_idx;
    logic        dump_ready = 1'b0;
    logic        busy;
    logic        timed_out;
`ifdef RUN_CTRL_CYCLE_COUNT_EN
    logic [15:0] run_cycles;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] regs [16];
    logic [31:0] ram  [32];
    logic [31:0] got_data [NREG];
    logic [3:0]  got_idx  [NREG];

    always #5 clock = ~clock;

    run_controller #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .NREG(NREG)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .prog_len   (prog_len),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .p_addr     (p_addr),
        .p_wr       (p_wr),
        .p_wdata    (p_wdata),
        .p_working  (p_working),
        .p_rID      (p_rID),
        .p_rdata    (p_rdata),
        .p_halted   (p_halted),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_idx   (dump_idx),
        .dump_ready (dump_ready),
        .busy       (busy),
        .timed_out  (timed_out)
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        ,.run_cycles (run_cycles)
`endif
    );

    // Processor model: combinational register read, synchronous RAM write
    assign p_rdata = regs[p_rID];
    always @(posedge clock) if (p_wr) ram[p_addr[4:0]] <= p_wdata;

    function automatic logic [31:0] exp_reg(input int k);
        if (k == 0) return 32'd1;
        if (k == 1) return 32'd2;
        return 32'hC0DE_0000 + 32'(k);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [5:0] len);
        start    = 1'b1;
        prog_len = len;
        cyc();
        start    = 1'b0;
    endtask

    // Called in the first RUN cycle; counts low cycles before p_working rises
    // and high cycles until it falls, raising p_halted on high cycle halt_at.
    task automatic run_phase(input int halt_at, output int pre_low, output int hi, output bit ok);
        pre_low = 0; hi = 0; ok = 0;
        for (int c = 0; c < TIMEOUT + 20; c++) begin
            if (p_working === 1'b1) begin
                p_halted = (hi == halt_at);
                hi++;
            end else if (hi == 0) begin
                pre_low++;
            end else begin
                ok = 1;
                break;
            end
            cyc();
        end
        p_halted = 1'b0;
    endtask

    // Called in the first DRAIN cycle; counts cycles before p_rID leaves 0xF
    task automatic walk_drain(output int n);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (p_rID !== 4'hF) break;
            n++;
            cyc();
        end
    endtask

    // Called in the first DUMP cycle; accepts NREG words, optionally stalling
    // stall_n valid cycles at stall_idx and pulsing start once mid-dump.
    task automatic collect_dump(input int stall_idx, input int stall_n, input bit poke_start,
                                output int ncyc, output bit stable_ok, output bit ok);
        int          cnt;
        int          left;
        bit          seen;
        bit          poked;
        logic [31:0] held;
        cnt = 0; left = stall_n; seen = 0; poked = 0; held = 32'd0;
        ncyc = 0; stable_ok = 1; ok = 0;
        for (int c = 0; c < 200; c++) begin
            ncyc++;
            start = 1'b0;
            if (dump_valid === 1'b1) begin
                if (poke_start && !poked) begin
                    start    = 1'b1;
                    prog_len = 6'd5;
                    poked    = 1;
                end
                if (int'(dump_idx) == stall_idx) begin
                    if (seen && dump_data !== held) stable_ok = 0;
                    held = dump_data;
                    seen = 1;
                end
                if (int'(dump_idx) == stall_idx && left > 0) begin
                    left--;
                    dump_ready = 1'b0;
                end else begin
                    dump_ready    = 1'b1;
                    got_data[cnt] = dump_data;
                    got_idx[cnt]  = dump_idx;
                    cnt++;
                end
            end else begin
                dump_ready = 1'b0;
                if (seen && left > 0) stable_ok = 0;
            end
            cyc();
            if (cnt == NREG) begin
                ok = 1;
                break;
            end
        end
        dump_ready = 1'b0;
        start      = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        tests_run++;
        if ({p_addr, p_wr, p_wdata, ld_ready, dump_valid, dump_data, dump_idx, timed_out} !== 103'd0) begin
            tests_failed++;
            $display("FAIL reset_zero_outputs: got addr=%h wr=%b wdata=%h rdy=%b dv=%b dd=%h di=%h to=%b want all 0",
                     p_addr, p_wr, p_wdata, ld_ready, dump_valid, dump_data, dump_idx, timed_out);
        end
        tests_run++;
        if (p_rID !== 4'hF || p_working !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rID=%h working=%b busy=%b want F 0 0", p_rID, p_working, busy);
        end
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        tests_run++;
        if (run_cycles !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_run_cycles: got %0d want 0", run_cycles);
        end
`endif
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_load_halt();
        logic [31:0] w [3];
        int pre, hi, nd, ncyc;
        bit ok, st;
        w[0] = 32'h10F0_0001; w[1] = 32'h10F1_0002; w[2] = 32'h1100_0000;
        do_start(6'd3);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = w[i];
            @(negedge clock);
            tests_run++;
            if (p_wr !== 1'b1 || p_addr !== 32'(i) || p_wdata !== w[i] || ld_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL load3_word[%0d]: got wr=%b addr=%0d data=%h rdy=%b want 1 %0d %h 1",
                         i, p_wr, p_addr, p_wdata, ld_ready, i, w[i]);
            end
            cyc();
        end
        @(negedge clock);
        tests_run++;
        if (ld_ready !== 1'b0 || p_wr !== 1'b0 || p_addr !== 32'd0 || p_working !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL load3_run_entry: got rdy=%b wr=%b addr=%h working=%b busy=%b want 0 0 0 0 1",
                     ld_ready, p_wr, p_addr, p_working, busy);
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ram[i] !== w[i]) begin
                tests_failed++;
                $display("FAIL load3_ram[%0d]: got %h want %h", i, ram[i], w[i]);
            end
        end
        run_phase(4, pre, hi, ok);
        tests_run++;
        if (!ok || pre != 1 || hi != 5) begin
            tests_failed++;
            $display("FAIL halt_run_len: got ok=%0d pre=%0d hi=%0d want 1 1 5", ok, pre, hi);
        end
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_timed_out: got %b want 0", timed_out);
        end
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        tests_run++;
        if (run_cycles !== 16'd5) begin
            tests_failed++;
            $display("FAIL halt_run_cycles: got %0d want 5", run_cycles);
        end
`endif
        walk_drain(nd);
        tests_run++;
        if (nd != 2 || p_rID !== 4'd0 || dump_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_drain: got cycles=%0d rID=%h dv=%b want 2 0 0", nd, p_rID, dump_valid);
        end
        collect_dump(-1, 0, 0, ncyc, st, ok);
        tests_run++;
        if (!ok || ncyc != 16) begin
            tests_failed++;
            $display("FAIL halt_dump_len: got ok=%0d cycles=%0d want 1 16", ok, ncyc);
        end
        for (int k = 0; k < NREG; k++) begin
            tests_run++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== exp_reg(k)) begin
                tests_failed++;
                $display("FAIL halt_dump_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h",
                         k, got_idx[k], got_data[k], k, exp_reg(k));
            end
        end
        tests_run++;
        if (p_rID !== 4'hF || busy !== 1'b1 || dump_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_done: got rID=%h busy=%b dv=%b want F 1 0", p_rID, busy, dump_valid);
        end
        cyc();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_timeout();
        int pre, hi, nd, ncyc;
        bit ok, st;
        do_start(6'd1);
        ld_valid = 1'b1;
        ld_data  = 32'h7000_0000;
        @(negedge clock);
        tests_run++;
        if (p_wr !== 1'b1 || p_addr !== 32'd0 || p_wdata !== 32'h7000_0000) begin
            tests_failed++;
            $display("FAIL tmo_load: got wr=%b addr=%h data=%h want 1 0 70000000", p_wr, p_addr, p_wdata);
        end
        cyc();
        ld_valid = 1'b0;
        run_phase(-1, pre, hi, ok);
        tests_run++;
        if (!ok || pre != 1 || hi != TIMEOUT) begin
            tests_failed++;
            $display("FAIL tmo_run_len: got ok=%0d pre=%0d hi=%0d want 1 1 %0d", ok, pre, hi, TIMEOUT);
        end
        tests_run++;
        if (timed_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_flag: got %b want 1", timed_out);
        end
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        tests_run++;
        if (run_cycles !== 16'd150) begin
            tests_failed++;
            $display("FAIL tmo_run_cycles: got %0d want 150", run_cycles);
        end
`endif
        walk_drain(nd);
        collect_dump(-1, 0, 0, ncyc, st, ok);
        tests_run++;
        if (!ok || ncyc != 16 || nd != 2) begin
            tests_failed++;
            $display("FAIL tmo_dump_len: got ok=%0d cycles=%0d drain=%0d want 1 16 2", ok, ncyc, nd);
        end
        for (int k = 0; k < NREG; k++) begin
            tests_run++;
            if (got_idx[k] !== 4'(k)) begin
                tests_failed++;
                $display("FAIL tmo_dump_idx[%0d]: got %0d want %0d", k, got_idx[k], k);
            end
        end
        cyc();
        tests_run++;
        if (busy !== 1'b0 || timed_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_sticky: got busy=%b to=%b want 0 1", busy, timed_out);
        end
    endtask

    task automatic test_halt_at_limit();
        int pre, hi, nd, ncyc;
        bit ok, st;
        do_start(6'd0);
        tests_run++;
        if (timed_out !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b0 || p_working !== 1'b0) begin
            tests_failed++;
            $display("FAIL limit_start: got to=%b busy=%b rdy=%b working=%b want 0 1 0 0",
                     timed_out, busy, ld_ready, p_working);
        end
        run_phase(TIMEOUT - 1, pre, hi, ok);
        tests_run++;
        if (!ok || hi != TIMEOUT || timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL limit_halt_wins: got ok=%0d hi=%0d to=%b want 1 %0d 0", ok, hi, timed_out, TIMEOUT);
        end
        walk_drain(nd);
        collect_dump(-1, 0, 0, ncyc, st, ok);
        cyc();
    endtask

    task automatic test_valid_toggle();
        int pre, hi, nd, ncyc, xf;
        bit ok, st;
        logic [31:0] expw [4];
        xf = 0;
        do_start(6'd4);
        for (int i = 0; i < 7; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = 32'hA000_0000 + 32'(i);
            @(negedge clock);
            tests_run++;
            if (p_wr !== ld_valid || p_addr !== 32'(xf) || ld_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL toggle_cycle[%0d]: got wr=%b addr=%0d rdy=%b want %b %0d 1",
                         i, p_wr, p_addr, ld_ready, ld_valid, xf);
            end
            if (ld_valid) begin
                expw[xf] = ld_data;
                xf++;
            end
            cyc();
        end
        ld_valid = 1'b1;
        @(negedge clock);
        tests_run++;
        if (ld_ready !== 1'b0 || p_wr !== 1'b0) begin
            tests_failed++;
            $display("FAIL toggle_ready_drop: got rdy=%b wr=%b want 0 0", ld_ready, p_wr);
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (ram[i] !== expw[i]) begin
                tests_failed++;
                $display("FAIL toggle_ram[%0d]: got %h want %h", i, ram[i], expw[i]);
            end
        end
        run_phase(0, pre, hi, ok);
        tests_run++;
        if (!ok || hi != 1) begin
            tests_failed++;
            $display("FAIL toggle_run_len: got ok=%0d hi=%0d want 1 1", ok, hi);
        end
        walk_drain(nd);
        collect_dump(-1, 0, 0, ncyc, st, ok);
        cyc();
    endtask

    task automatic test_dump_stall();
        int pre, hi, nd, ncyc;
        bit ok, st;
        do_start(6'd0);
        run_phase(2, pre, hi, ok);
        walk_drain(nd);
        collect_dump(2, 5, 0, ncyc, st, ok);
        tests_run++;
        if (!ok || !st || ncyc != 21) begin
            tests_failed++;
            $display("FAIL stall_dump: got ok=%0d stable=%0d cycles=%0d want 1 1 21", ok, st, ncyc);
        end
        for (int k = 0; k < NREG; k++) begin
            tests_run++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== exp_reg(k)) begin
                tests_failed++;
                $display("FAIL stall_dump_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h",
                         k, got_idx[k], got_data[k], k, exp_reg(k));
            end
        end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        int n, pre, hi, nd, ncyc;
        bit ok, st;
        n = 0;
        do_start(6'd0);
        for (int c = 0; c < 40; c++) begin
            if (p_working === 1'b1) n++;
            if (n == 10) break;
            cyc();
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (n != 10 || p_working !== 1'b0 || p_wr !== 1'b0 || busy !== 1'b0 || p_rID !== 4'hF) begin
            tests_failed++;
            $display("FAIL midrst_async: got n=%0d working=%b wr=%b busy=%b rID=%h want 10 0 0 0 F",
                     n, p_working, p_wr, busy, p_rID);
        end
        reset = 1'b0;
        cyc();
        do_start(6'd0);
        tests_run++;
        if (busy !== 1'b1 || ld_ready !== 1'b0 || p_wr !== 1'b0 || p_working !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_restart: got busy=%b rdy=%b wr=%b working=%b want 1 0 0 0",
                     busy, ld_ready, p_wr, p_working);
        end
        run_phase(1, pre, hi, ok);
        tests_run++;
        if (!ok || pre != 1 || hi != 2) begin
            tests_failed++;
            $display("FAIL midrst_run_len: got ok=%0d pre=%0d hi=%0d want 1 1 2", ok, pre, hi);
        end
        walk_drain(nd);
        collect_dump(-1, 0, 0, ncyc, st, ok);
        cyc();
    endtask

    task automatic test_start_in_dump();
        int pre, hi, nd, ncyc;
        bit ok, st;
        do_start(6'd0);
        run_phase(6, pre, hi, ok);
        tests_run++;
        if (!ok || hi != 7) begin
            tests_failed++;
            $display("FAIL poke_run_len: got ok=%0d hi=%0d want 1 7", ok, hi);
        end
`ifdef RUN_CTRL_CYCLE_COUNT_EN
        tests_run++;
        if (run_cycles !== 16'd7) begin
            tests_failed++;
            $display("FAIL poke_run_cycles: got %0d want 7", run_cycles);
        end
`endif
        walk_drain(nd);
        collect_dump(-1, 0, 1, ncyc, st, ok);
        tests_run++;
        if (!ok || ncyc != 16) begin
            tests_failed++;
            $display("FAIL poke_dump_len: got ok=%0d cycles=%0d want 1 16", ok, ncyc);
        end
        for (int k = 0; k < NREG; k++) begin
            tests_run++;
            if (got_idx[k] !== 4'(k) || got_data[k] !== exp_reg(k)) begin
                tests_failed++;
                $display("FAIL poke_dump_word[%0d]: got idx=%0d data=%h want idx=%0d data=%h",
                         k, got_idx[k], got_data[k], k, exp_reg(k));
            end
        end
        cyc();
        cyc();
        tests_run++;
        if (busy !== 1'b0 || ld_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL poke_ignored: got busy=%b rdy=%b want 0 0", busy, ld_ready);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) regs[k] = (k == 15) ? 32'hDEAD_BEEF : exp_reg(k);
        for (int k = 0; k < 32; k++) ram[k] = 32'd0;
        test_reset();
        test_load_halt();
        test_timeout();
        test_halt_at_limit();
        test_valid_toggle();
        test_dump_stall();
        test_reset_mid_run();
        test_start_in_dump();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
